// File: rtl/dr_uart_dump.sv
// dr_uart_dump
//   Watches the CPU core's 32-bit debug register and sends each new value over
//   a UART 8N1 line as eight uppercase hex ASCII characters followed by CR LF.
//   A single-entry pending slot holds the newest value while a frame is in
//   flight. Values overwritten in that slot before being sent are counted.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   dr          debug register value from the core (may change on any edge)
//   tx          UART serial output, idle high (registered)
//   busy        high while a frame is being transmitted (registered)
//   drop_count  saturating count of overwritten pending values (registered)
//
// Parameter
//   ClkPerBit   clock cycles per UART bit, legal range 2..65535
module dr_uart_dump #(
  parameter int unsigned ClkPerBit = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dr,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  drop_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } state_t;

  localparam logic [15:0] BaudLast = 16'(ClkPerBit - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [31:0] last_seen_q;
  logic [31:0] pend_val_q;
  logic [31:0] frame_val_q;
  logic        pending_q;
  logic [7:0]  drop_q;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        chain_q;
  logic        baud_done;
  logic        change;
  logic [7:0]  cur_char;

  // ASCII character for byte position idx of a frame carrying value v:
  // positions 0..7 are the nibbles MSB first, then CR, then LF.
  function automatic logic [7:0] char_at(input logic [31:0] v,
                                         input logic [3:0]  idx);
    logic [4:0] sh;
    logic [3:0] nib;
    sh  = {~idx[2:0], 2'b00};  // 4 * (7 - idx)
    nib = v[sh +: 4];
    if (idx == 4'd8)       return 8'h0D;
    else if (idx == 4'd9)  return 8'h0A;
    else if (nib < 4'd10)  return 8'h30 + {4'h0, nib};
    else                   return 8'h37 + {4'h0, nib};
  endfunction

  assign baud_done = (baud_q == BaudLast);
  assign change    = (dr != last_seen_q);

  // State register.
  // NOTE: every flop in this block and below is written with non-blocking
  // assignments so all registers update together from the pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic, including the bit/byte position that travels with it.
  // NOTE: each variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    unique case (state_q)
      IDLE:  if (pending_q) state_d = LOAD;
      LOAD: begin
        state_d    = START;
        byte_idx_d = '0;
      end
      START: if (baud_done) begin
        state_d   = DATA;
        bit_idx_d = '0;
      end
      DATA: if (baud_done) begin
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (baud_done) begin
        if (byte_idx_q == 4'd9) begin
          state_d = IDLE;
        end else begin
          byte_idx_d = byte_idx_q + 4'd1;
          state_d    = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: computes the value tx/busy must hold while in the next
  // state, so the registered outputs line up with the state register.
  always_comb begin
    tx_d     = 1'b1;
    busy_d   = busy_q;
    cur_char = char_at(frame_val_q, byte_idx_d);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_char[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    if (state_d == IDLE)       busy_d = 1'b0;
    else if (state_q == LOAD)  busy_d = 1'b1;
    // Entering LOAD straight after a frame keeps busy low for only the single
    // IDLE cycle between chained frames; a fresh frame raises it after LOAD.
    else if (state_q == IDLE)  busy_d = chain_q;
  end

  // Datapath: baud timer, change detect, pending slot, output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_q      <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      last_seen_q <= '0;
      pend_val_q  <= '0;
      frame_val_q <= '0;
      pending_q   <= 1'b0;
      drop_q      <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      chain_q     <= 1'b0;
    end else begin
      // Timer restarts on every bit boundary and is held at 0 outside the line.
      if ((state_q == START || state_q == DATA || state_q == STOP) && !baud_done)
        baud_q <= baud_q + 16'd1;
      else
        baud_q <= '0;

      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;

      if (state_q == LOAD) frame_val_q <= pend_val_q;

      // A change on the LOAD edge re-arms the slot and is not a drop, since
      // the previous pending value is being consumed on that same edge.
      if (change) begin
        last_seen_q <= dr;
        pend_val_q  <= dr;
        pending_q   <= 1'b1;
        if (pending_q && state_q != LOAD && drop_q != 8'hFF)
          drop_q <= drop_q + 8'd1;
      end else if (state_q == LOAD) begin
        pending_q <= 1'b0;
      end

      tx_q    <= tx_d;
      busy_q  <= busy_d;
      chain_q <= (state_q == STOP) && (state_d == IDLE);
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_dr_uart_dump.sv
// Testbench for dr_uart_dump: table-driven frame vectors plus hand-written
// sequences for back-to-back frames, duplicate writes, mid-frame reset and
// drop-count saturation. A background UART monitor decodes tx at bit centres.
module tb_dr_uart_dump;

  localparam int Cpb = 4;

  logic        clk;
  logic        reset;
  logic [31:0] dr;
  logic        tx;
  logic        busy;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];

  typedef struct {
    logic [31:0] dr;
    logic [63:0] hex;
  } vec_t;

  vec_t vecs[5];

  dr_uart_dump #(.ClkPerBit(Cpb)) dut (
    .clk        (clk),
    .reset      (reset),
    .dr         (dr),
    .tx         (tx),
    .busy       (busy),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Receive one 10-byte frame; cycle 0 is the first start-bit cycle.
  // Abandons the frame silently if reset is asserted.
  task automatic rx_frame();
    int cyc = 0;
    logic [7:0] b = '0;
    for (int p = 0; p < 100; p++) begin
      while (cyc < Cpb * p + Cpb / 2) begin
        @(negedge clk);
        cyc++;
        if (reset) return;
      end
      if (p % 10 == 0) begin
        check("start_bit", 80'(tx), 80'(0));
      end else if (p % 10 == 9) begin
        check("stop_bit", 80'(tx), 80'(1));
        rx_q.push_back(b);
      end else begin
        b[(p % 10) - 1] = tx;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) rx_frame();
    end
  end

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("rx_byte_count", 80'(rx_q.size() >= n), 80'(1));
  endtask

  task automatic pop_frame(output logic [79:0] f);
    f = '0;
    for (int i = 0; i < 10; i++) begin
      if (rx_q.size() > 0) f = {f[71:0], rx_q.pop_front()};
      else                 f = {f[71:0], 8'h00};
    end
  endtask

  // Returns the number of negedges until tx is seen low (bounded).
  task automatic wait_tx_fall(input int budget, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (tx === 1'b1 && cnt < budget);
  endtask

  task automatic wait_busy_low(input int budget);
    int k = 0;
    while (busy === 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int blen;
    int bad;
    int low;
    int gap;
    logic [79:0] f;

    vecs[0] = '{32'h1234ABCD, "1234ABCD"};
    vecs[1] = '{32'hDEADBEEF, "DEADBEEF"};
    vecs[2] = '{32'h0F1E2D3C, "0F1E2D3C"};
    vecs[3] = '{32'h9000000A, "9000000A"};
    vecs[4] = '{32'h00000007, "00000007"};

    // Reset state, then dr held at zero: nothing may be sent.
    reset = 1'b1;
    dr    = '0;
    #1;
    check("reset_tx", 80'(tx), 80'(1));
    check("reset_busy", 80'(busy), 80'(0));
    check("reset_drop", 80'(drop_count), 80'(0));
    repeat (3) @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || drop_count !== 8'd0) bad++;
    end
    check("idle_quiet", 80'(bad), 80'(0));
    check("idle_no_bytes", 80'(rx_q.size()), 80'(0));

    // Single frames: start latency, busy width, decoded text, no drops.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dr = vecs[i].dr;
      wait_tx_fall(20, cnt);
      check("fall_latency", 80'(cnt - 1), 80'(2));
      blen = 0;
      while (busy === 1'b1 && blen < 1000) begin
        blen++;
        @(negedge clk);
      end
      check("busy_len", 80'(blen), 80'(400));
      wait_bytes(10, 100);
      pop_frame(f);
      check("frame_text", f, {vecs[i].hex, 16'h0D0A});
      check("frame_drop", 80'(drop_count), 80'(0));
    end

    // Rewriting the same value (0x00000007) must not start a frame.
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      dr = 32'h00000007;
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("same_value_quiet", 80'(bad), 80'(0));
    check("same_value_no_bytes", 80'(rx_q.size()), 80'(0));

    // Back-to-back: 5 is overwritten by 6 while 0xFFFFFFFF is on the line.
    @(negedge clk);
    dr = 32'hFFFFFFFF;
    wait_tx_fall(20, cnt);
    repeat (40) @(negedge clk);
    dr = 32'h00000005;
    @(negedge clk);
    dr = 32'h00000006;
    wait_busy_low(500);
    check("b2b_busy_fell", 80'(busy), 80'(0));
    low = 1;
    gap = 0;
    while (gap < 20) begin
      @(negedge clk);
      gap++;
      if (busy === 1'b0) low++;
      if (tx === 1'b0) break;
    end
    check("b2b_start_gap", 80'(gap), 80'(2));
    check("b2b_busy_low", 80'(low), 80'(1));
    check("b2b_drop", 80'(drop_count), 80'(1));
    wait_bytes(20, 600);
    pop_frame(f);
    check("b2b_frame1", f, {"FFFFFFFF", 16'h0D0A});
    pop_frame(f);
    check("b2b_frame2", f, {"00000006", 16'h0D0A});
    wait_busy_low(100);

    // Reset in the middle of byte 3, then a fresh frame of the same value.
    @(negedge clk);
    dr = 32'hA5A50001;
    wait_tx_fall(20, cnt);
    repeat (3 * 10 * Cpb + 5) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_tx", 80'(tx), 80'(1));
    check("async_rst_busy", 80'(busy), 80'(0));
    check("async_rst_drop", 80'(drop_count), 80'(0));
    repeat (2) @(negedge clk);
    rx_q.delete();
    reset = 1'b0;
    wait_tx_fall(20, cnt);
    check("rst_resend_latency", 80'(cnt - 1), 80'(2));
    wait_busy_low(500);
    wait_bytes(10, 100);
    pop_frame(f);
    check("rst_resend_frame", f, {"A5A50001", 16'h0D0A});
    check("rst_resend_count", 80'(rx_q.size()), 80'(0));

    // Saturation: 300 distinct values during one frame; only the last is sent.
    @(negedge clk);
    dr = 32'h11111111;
    wait_tx_fall(20, cnt);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      dr = 32'h80000000 + 32'(i);
      @(negedge clk);
    end
    check("sat_drop", 80'(drop_count), 80'(255));
    check("sat_still_busy", 80'(busy), 80'(1));
    wait_bytes(20, 1000);
    pop_frame(f);
    check("sat_frame1", f, {"11111111", 16'h0D0A});
    pop_frame(f);
    check("sat_frame2", f, {"8000012B", 16'h0D0A});
    wait_busy_low(200);
    repeat (300) @(negedge clk);
    check("sat_no_more_bytes", 80'(rx_q.size()), 80'(0));
    check("sat_idle_busy", 80'(busy), 80'(0));
    check("sat_drop_hold", 80'(drop_count), 80'(255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
